// File: rtl/dispenser_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dispenser_pkg
// Purpose : Shared types and constants for the change dispenser. Holds the
//           payout FSM state encoding, the note_sel codes driven to the
//           note-drop mechanism, and the face value of each note in Tk.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package dispenser_pkg;

  // Payout sequencer states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PICK    = 3'd2,
    ISSUE   = 3'd3,
    RELEASE = 3'd4,
    FINISH  = 3'd5
  } state_t;

  // note_sel encoding seen by the mechanism
  localparam logic [1:0] NOTE_NONE = 2'b00;
  localparam logic [1:0] NOTE_5    = 2'b01;
  localparam logic [1:0] NOTE_10   = 2'b10;
  localparam logic [1:0] NOTE_20   = 2'b11;

  // Face values in Tk; the top resizes these to its amount width
  localparam int unsigned VAL_5  = 5;
  localparam int unsigned VAL_10 = 10;
  localparam int unsigned VAL_20 = 20;

endpackage : dispenser_pkg
`default_nettype wire

// File: rtl/rise_edge.sv
`default_nettype none
// ============================================================================
// Module  : rise_edge
// Purpose : Single-cycle rising-edge detector for a slow level input.
//           The history register comes out of reset high, so a level that is
//           already high while reset is asserted never produces a pulse.
// Ports   : clk    in  system clock
//           reset  in  synchronous active-high reset
//           level  in  level input to watch
//           rise   out combinational pulse, high while level=1 and prev=0
// Revision: 1.0  initial release
// ============================================================================
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= level;
    end
  end

  assign rise = level & ~r_prev;

endmodule : rise_edge
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module  : change_dispenser
// Purpose : Pays out a customer's balance as 20/10/5 Tk notes, greedy
//           largest-first and limited by note inventory, through a req/ack
//           note-drop mechanism. Reports the unpaid remainder and pulses
//           clear_balance on a normal end; an ack timeout raises a sticky
//           fault instead.
// Ports   : clk, reset            clock, synchronous active-high reset
//           refund, refill        button / service-switch levels (rising edge acts)
//           balance[AMT_W]        amount to pay, sampled at payout start
//           note_ack              mechanism acknowledge
//           note_req, note_sel    note drop request and denomination
//           busy, done            payout in progress / one-cycle end pulse
//           clear_balance         one-cycle pulse with done on a normal end
//           owed[AMT_W]           amount left unpaid at the last payout end
//           fault                 sticky ack-timeout flag
//           inv20/inv10/inv5      current note inventories
// Revision: 1.0  initial release
// ============================================================================
module change_dispenser
  import dispenser_pkg::*;
#(
  parameter int AMT_W    = 8,
  parameter int INV_W    = 4,
  parameter int INIT_N20 = 4,
  parameter int INIT_N10 = 6,
  parameter int INIT_N5  = 8,
  parameter int TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refund,
  input  logic             refill,
  input  logic [AMT_W-1:0] balance,
  input  logic             note_ack,
  output logic             note_req,
  output logic [1:0]       note_sel,
  output logic             busy,
  output logic             done,
  output logic             clear_balance,
  output logic [AMT_W-1:0] owed,
  output logic             fault,
  output logic [INV_W-1:0] inv20,
  output logic [INV_W-1:0] inv10,
  output logic [INV_W-1:0] inv5
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [AMT_W-1:0] C_VAL20  = AMT_W'(VAL_20);
  localparam logic [AMT_W-1:0] C_VAL10  = AMT_W'(VAL_10);
  localparam logic [AMT_W-1:0] C_VAL5   = AMT_W'(VAL_5);
  localparam logic [INV_W-1:0] C_INIT20 = INV_W'(INIT_N20);
  localparam logic [INV_W-1:0] C_INIT10 = INV_W'(INIT_N10);
  localparam logic [INV_W-1:0] C_INIT5  = INV_W'(INIT_N5);
  localparam logic [TMR_W-1:0] C_TLAST  = TMR_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [AMT_W-1:0] r_rem;
  logic [TMR_W-1:0] r_timer;
  logic             r_req;
  logic [1:0]       r_sel;
  logic             r_busy;
  logic             r_done;
  logic             r_clear;
  logic [AMT_W-1:0] r_owed;
  logic             r_fault;
  logic [INV_W-1:0] r_inv20;
  logic [INV_W-1:0] r_inv10;
  logic [INV_W-1:0] r_inv5;

  logic             w_refund_rise;
  logic             w_refill_rise;
  logic [1:0]       w_pick_sel;
  logic [AMT_W-1:0] w_sel_value;
  logic             w_timeout;

  rise_edge u_refund_edge (
    .clk   (clk),
    .reset (reset),
    .level (refund),
    .rise  (w_refund_rise)
  );

  rise_edge u_refill_edge (
    .clk   (clk),
    .reset (reset),
    .level (refill),
    .rise  (w_refill_rise)
  );

  // Greedy choice: largest note that fits the remainder and is still stocked.
  // Comparing before any subtraction keeps r_rem from ever wrapping.
  always_comb begin
    w_pick_sel = NOTE_NONE;
    if (r_rem >= C_VAL20 && r_inv20 != '0) begin
      w_pick_sel = NOTE_20;
    end else if (r_rem >= C_VAL10 && r_inv10 != '0) begin
      w_pick_sel = NOTE_10;
    end else if (r_rem >= C_VAL5 && r_inv5 != '0) begin
      w_pick_sel = NOTE_5;
    end
  end

  // Value of the note currently being dropped
  always_comb begin
    w_sel_value = '0;
    case (r_sel)
      NOTE_20: w_sel_value = C_VAL20;
      NOTE_10: w_sel_value = C_VAL10;
      NOTE_5:  w_sel_value = C_VAL5;
      default: w_sel_value = '0;
    endcase
  end

  // Timer has counted TIMEOUT cycles in the current wait state
  assign w_timeout = (r_timer == C_TLAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_rem   <= '0;
      r_timer <= '0;
      r_req   <= 1'b0;
      r_sel   <= NOTE_NONE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_clear <= 1'b0;
      r_owed  <= '0;
      r_fault <= 1'b0;
      r_inv20 <= C_INIT20;
      r_inv10 <= C_INIT10;
      r_inv5  <= C_INIT5;
    end else begin
      r_done  <= 1'b0;
      r_clear <= 1'b0;

      case (r_state)
        IDLE: begin
          // A refund edge takes priority; a refill edge in the same cycle is lost.
          if (w_refund_rise && !r_fault) begin
            r_busy  <= 1'b1;
            r_owed  <= '0;
            r_state <= LOAD;
          end else if (w_refill_rise) begin
            r_inv20 <= C_INIT20;
            r_inv10 <= C_INIT10;
            r_inv5  <= C_INIT5;
            r_fault <= 1'b0;
          end
        end

        LOAD: begin
          r_rem   <= balance;
          r_state <= PICK;
        end

        PICK: begin
          if (w_pick_sel != NOTE_NONE) begin
            r_sel   <= w_pick_sel;
            r_req   <= 1'b1;
            r_timer <= '0;
            r_state <= ISSUE;
          end else begin
            r_state <= FINISH;
          end
        end

        ISSUE: begin
          if (note_ack) begin
            // Note has dropped: account for it on this same edge
            r_req   <= 1'b0;
            r_sel   <= NOTE_NONE;
            r_rem   <= r_rem - w_sel_value;
            r_timer <= '0;
            case (r_sel)
              NOTE_20: r_inv20 <= r_inv20 - 1'b1;
              NOTE_10: r_inv10 <= r_inv10 - 1'b1;
              NOTE_5:  r_inv5  <= r_inv5 - 1'b1;
              default: ;
            endcase
            r_state <= RELEASE;
          end else if (w_timeout) begin
            // Pending note never confirmed, so inventory is left alone
            r_req   <= 1'b0;
            r_sel   <= NOTE_NONE;
            r_fault <= 1'b1;
            r_owed  <= r_rem;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        RELEASE: begin
          if (!note_ack) begin
            r_state <= PICK;
          end else if (w_timeout) begin
            r_fault <= 1'b1;
            r_owed  <= r_rem;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        FINISH: begin
          // Counter is told to zero even when part of the balance is owed
          r_owed  <= r_rem;
          r_done  <= 1'b1;
          r_clear <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign note_req      = r_req;
  assign note_sel      = r_sel;
  assign busy          = r_busy;
  assign done          = r_done;
  assign clear_balance = r_clear;
  assign owed          = r_owed;
  assign fault         = r_fault;
  assign inv20         = r_inv20;
  assign inv10         = r_inv10;
  assign inv5          = r_inv5;

endmodule : change_dispenser
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module  : tb_change_dispenser
// Purpose : Directed self-checking bench for change_dispenser. A behavioural
//           note mechanism acks 3 cycles after a request and drops ack 2
//           cycles after the request falls; it logs every note it drops.
// Revision: 1.0  initial release
// ============================================================================
module tb_change_dispenser;

  logic       clk;
  logic       reset;
  logic       refund;
  logic       refill;
  logic [7:0] balance;
  logic       note_ack;
  logic       note_req;
  logic [1:0] note_sel;
  logic       busy;
  logic       done;
  logic       clear_balance;
  logic [7:0] owed;
  logic       fault;
  logic [3:0] inv20;
  logic [3:0] inv10;
  logic [3:0] inv5;

  int total = 0;
  int bad   = 0;

  bit         ack_en = 1'b1;
  logic [1:0] note_log[$];

  change_dispenser dut (
    .clk           (clk),
    .reset         (reset),
    .refund        (refund),
    .refill        (refill),
    .balance       (balance),
    .note_ack      (note_ack),
    .note_req      (note_req),
    .note_sel      (note_sel),
    .busy          (busy),
    .done          (done),
    .clear_balance (clear_balance),
    .owed          (owed),
    .fault         (fault),
    .inv20         (inv20),
    .inv10         (inv10),
    .inv5          (inv5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Note-drop mechanism model
  initial begin
    note_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (note_req && ack_en) begin
        repeat (2) @(negedge clk);
        note_log.push_back(note_sel);
        note_ack = 1'b1;
        for (int k = 0; k < 50 && note_req; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        note_ack = 1'b0;
      end
    end
  end

  // Global watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Dropped notes packed two bits each, oldest in the most significant place
  function automatic logic [31:0] log_word();
    logic [31:0] w = '0;
    foreach (note_log[i]) w = (w << 2) | 32'(note_log[i]);
    return w;
  endfunction

  // Starts one payout and runs until done (bounded); counts done/clear pulses
  task automatic payout(input logic [7:0] bal, output int n_done, output int n_clr,
                        output bit to_flag);
    note_log.delete();
    n_done  = 0;
    n_clr   = 0;
    to_flag = 1'b1;
    balance = bal;
    refund  = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (clear_balance) n_clr++;
      if (done) begin
        to_flag = 1'b0;
        break;
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
      if (clear_balance) n_clr++;
    end
    refund = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; refund = 1'b0; refill = 1'b0; balance = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (note_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", note_req); end
    total++; if (note_sel !== 2'b00) begin bad++; $display("FAIL reset_sel: got %b want 00", note_sel); end
    total++; if ({busy, done, clear_balance, fault} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {busy, done, clear_balance, fault}); end
    total++; if (owed !== 8'd0) begin bad++; $display("FAIL reset_owed: got %0d want 0", owed); end
    total++; if ({inv20, inv10, inv5} !== {4'd4, 4'd6, 4'd8}) begin bad++; $display("FAIL reset_inv: got %0d/%0d/%0d want 4/6/8", inv20, inv10, inv5); end
  endtask

  task automatic test_basic_35();
    int nd, nc; bit to;
    payout(8'd35, nd, nc, to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL p35_timeout: got no done want done"); end
    total++; if (note_log.size() !== 3 || log_word() !== 32'b11_10_01) begin bad++; $display("FAIL p35_notes: got %0d notes %b want 3 notes 111001", note_log.size(), log_word()); end
    total++; if (nd !== 1 || nc !== 1) begin bad++; $display("FAIL p35_pulses: got done=%0d clr=%0d want 1/1", nd, nc); end
    total++; if (owed !== 8'd0) begin bad++; $display("FAIL p35_owed: got %0d want 0", owed); end
    total++; if ({inv20, inv10, inv5} !== {4'd3, 4'd5, 4'd7}) begin bad++; $display("FAIL p35_inv: got %0d/%0d/%0d want 3/5/7", inv20, inv10, inv5); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL p35_busy: got %b want 0", busy); end
  endtask

  task automatic test_remainder_17();
    int nd, nc; bit to;
    payout(8'd17, nd, nc, to);
    total++; if (to !== 1'b0 || note_log.size() !== 2 || log_word() !== 32'b10_01) begin bad++; $display("FAIL p17_notes: got %0d notes %b to=%b want 2 notes 1001", note_log.size(), log_word(), to); end
    total++; if (owed !== 8'd2) begin bad++; $display("FAIL p17_owed: got %0d want 2", owed); end
    total++; if (nc !== 1 || nd !== 1) begin bad++; $display("FAIL p17_pulses: got done=%0d clr=%0d want 1/1", nd, nc); end
    total++; if ({inv20, inv10, inv5} !== {4'd3, 4'd4, 4'd6}) begin bad++; $display("FAIL p17_inv: got %0d/%0d/%0d want 3/4/6", inv20, inv10, inv5); end
  endtask

  // Brings inventory to 20x1, 10x0, 5x2
  task automatic test_drain();
    int nd, nc; bit to;
    payout(8'd40, nd, nc, to);
    total++; if (to !== 1'b0 || log_word() !== 32'b11_11 || note_log.size() !== 2) begin bad++; $display("FAIL drain40_notes: got %0d notes %b want 2 notes 1111", note_log.size(), log_word()); end
    for (int r = 0; r < 4; r++) begin
      payout(8'd15, nd, nc, to);
      total++; if (to !== 1'b0 || log_word() !== 32'b10_01 || owed !== 8'd0) begin bad++; $display("FAIL drain15_%0d: got notes %b owed %0d want 1001 owed 0", r, log_word(), owed); end
    end
    total++; if ({inv20, inv10, inv5} !== {4'd1, 4'd0, 4'd2}) begin bad++; $display("FAIL drain_inv: got %0d/%0d/%0d want 1/0/2", inv20, inv10, inv5); end
  endtask

  task automatic test_inventory_limit();
    int nd, nc; bit to;
    payout(8'd40, nd, nc, to);
    total++; if (to !== 1'b0 || note_log.size() !== 3 || log_word() !== 32'b11_01_01) begin bad++; $display("FAIL lim_notes: got %0d notes %b want 3 notes 110101", note_log.size(), log_word()); end
    total++; if (owed !== 8'd10) begin bad++; $display("FAIL lim_owed: got %0d want 10", owed); end
    total++; if (nc !== 1) begin bad++; $display("FAIL lim_clear: got %0d want 1", nc); end
    total++; if ({inv20, inv10, inv5} !== 12'd0) begin bad++; $display("FAIL lim_inv: got %0d/%0d/%0d want 0/0/0", inv20, inv10, inv5); end
  endtask

  task automatic test_refill();
    refill = 1'b1;
    @(negedge clk);
    total++; if ({inv20, inv10, inv5} !== {4'd4, 4'd6, 4'd8}) begin bad++; $display("FAIL refill_inv: got %0d/%0d/%0d want 4/6/8", inv20, inv10, inv5); end
    refill = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout_fault();
    int cnt;
    int busy_seen;
    ack_en  = 1'b0;
    balance = 8'd20;
    refund  = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b1 || note_req !== 1'b0) begin bad++; $display("FAIL lat_busy: got busy=%b req=%b want 1/0", busy, note_req); end
    repeat (2) @(negedge clk);
    total++; if (note_req !== 1'b1 || note_sel !== 2'b11) begin bad++; $display("FAIL lat_req: got req=%b sel=%b want 1/11", note_req, note_sel); end
    cnt = -1;
    for (int i = 1; i <= 1200; i++) begin
      @(negedge clk);
      if (done) begin
        cnt = i;
        break;
      end
    end
    total++; if (cnt !== 1000) begin bad++; $display("FAIL to_cycles: got %0d want 1000", cnt); end
    total++; if ({fault, note_req, clear_balance, busy} !== 4'b1000) begin bad++; $display("FAIL to_flags: got fault/req/clr/busy=%b want 1000", {fault, note_req, clear_balance, busy}); end
    total++; if (owed !== 8'd20 || {inv20, inv10, inv5} !== {4'd4, 4'd6, 4'd8}) begin bad++; $display("FAIL to_state: got owed %0d inv %0d/%0d/%0d want 20 4/6/8", owed, inv20, inv10, inv5); end
    refund = 1'b0;
    @(negedge clk);
    refund = 1'b1;
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || note_req) busy_seen++;
    end
    total++; if (busy_seen !== 0) begin bad++; $display("FAIL fault_blocks: got %0d busy cycles want 0", busy_seen); end
    refund = 1'b0;
    refill = 1'b1;
    @(negedge clk);
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL refill_clear: got fault=%b want 0", fault); end
    refill = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_payout();
    int nd, nc, act; bit to;
    payout(8'd5, nd, nc, to);
    total++; if (inv5 !== 4'd7 || log_word() !== 32'b01) begin bad++; $display("FAIL pre5: got inv5 %0d notes %b want 7 01", inv5, log_word()); end
    ack_en  = 1'b0;
    balance = 8'd35;
    refund  = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (note_req !== 1'b1) begin bad++; $display("FAIL mid_req: got %b want 1", note_req); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (note_req !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_reset: got req=%b busy=%b want 0/0", note_req, busy); end
    total++; if (inv5 !== 4'd8) begin bad++; $display("FAIL mid_inv: got %0d want 8", inv5); end
    reset = 1'b0;
    act = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || note_req || done || clear_balance) act++;
    end
    total++; if (act !== 0) begin bad++; $display("FAIL held_refund: got %0d active cycles want 0", act); end
    refund = 1'b0;
    ack_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_simultaneous_edges();
    int nd, nc; bit to;
    payout(8'd5, nd, nc, to);
    note_log.delete();
    balance = 8'd10;
    refund  = 1'b1;
    refill  = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b1 || inv5 !== 4'd7) begin bad++; $display("FAIL both_edges: got busy=%b inv5=%0d want 1/7", busy, inv5); end
    refill = 1'b0;
    @(negedge clk);
    refill = 1'b1;
    nc = 0; to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (clear_balance) nc++;
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    total++; if (to !== 1'b0 || nc !== 1 || log_word() !== 32'b10) begin bad++; $display("FAIL both_payout: got to=%b clr=%0d notes %b want 0 1 10", to, nc, log_word()); end
    total++; if ({inv20, inv10, inv5} !== {4'd4, 4'd5, 4'd7}) begin bad++; $display("FAIL busy_refill: got %0d/%0d/%0d want 4/5/7", inv20, inv10, inv5); end
    refund = 1'b0;
    refill = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_35();
    test_remainder_17();
    test_drain();
    test_inventory_limit();
    test_refill();
    test_timeout_fault();
    test_reset_mid_payout();
    test_simultaneous_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_change_dispenser
`default_nettype wire
